// File: rtl/pc_select_if.sv
// ----------------------------------------------------------------------------
// pc_select_if
// Groups the fetch-stage signals of the next-PC selector.
//   I_interrupt : interrupt request level from the interrupt controller
//   I_mtvec     : trap vector base from the CSR file (XLEN)
//   I_data      : normal next-PC candidate from the PC-update logic (XLEN)
//   O_data      : selected next PC (XLEN)
//   O_trap      : high in the cycle a trap redirect is selected
//   O_mepc      : PC captured at the last trap redirect (XLEN)
// master modport: the surrounding core side (drives the I_* signals).
// slave modport : the pc_select block (drives the O_* signals).
// ----------------------------------------------------------------------------
interface pc_select_if #(
    parameter int XLEN = 32
);
    logic            I_interrupt;
    logic [XLEN-1:0] I_mtvec;
    logic [XLEN-1:0] I_data;
    logic [XLEN-1:0] O_data;
    logic            O_trap;
    logic [XLEN-1:0] O_mepc;

    modport master (
        output I_interrupt,
        output I_mtvec,
        output I_data,
        input  O_data,
        input  O_trap,
        input  O_mepc
    );

    modport slave (
        input  I_interrupt,
        input  I_mtvec,
        input  I_data,
        output O_data,
        output O_trap,
        output O_mepc
    );
endinterface

// File: rtl/pc_select.sv
// ----------------------------------------------------------------------------
// pc_select
// Next-PC source selector for the fetch stage. Forwards the normal next-PC
// candidate, or redirects to the trap vector on the first cycle an interrupt
// request is seen (rising-edge detect against the previous-cycle level), and
// captures the interrupted PC as mepc.
//
// Ports:
//   I_clk   : core clock, rising-edge active
//   I_rst_n : asynchronous active-low reset (clears int_q and mepc)
//   bus     : pc_select_if.slave (I_interrupt, I_mtvec, I_data in;
//             O_data, O_trap, O_mepc out)
//
// Optional build macro:
//   PC_SEL_ALIGN_EN : when defined, the trap target has mtvec[1:0] forced
//                     to 2'b00 (MODE bits ignored). When undefined, mtvec is
//                     passed through unmodified.
// ----------------------------------------------------------------------------
module pc_select #(
    parameter int XLEN = 32
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    pc_select_if.slave   bus
);

    logic            int_q;
    logic            int_d;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mepc_d;
    logic [XLEN-1:0] target;
    logic            trap;

    // Trap target selection.
    always_comb begin
        target = bus.I_mtvec;
`ifdef PC_SEL_ALIGN_EN
        // Drop the MODE bits so the vector is always word aligned.
        target = bus.I_mtvec & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif
    end

    // Redirect and next-state logic. The trap pulse is purely combinational,
    // so an interrupt rising between edges redirects immediately, and a level
    // held across an edge stops redirecting once int_q has sampled it.
    always_comb begin
        trap   = bus.I_interrupt & ~int_q;
        int_d  = bus.I_interrupt;
        mepc_d = mepc_q;
        if (trap) begin
            mepc_d = bus.I_data;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            int_q  <= 1'b0;
            mepc_q <= '0;
        end else begin
            int_q  <= int_d;
            mepc_q <= mepc_d;
        end
    end

    assign bus.O_trap = trap;
    assign bus.O_data = trap ? target : bus.I_data;
    assign bus.O_mepc = mepc_q;

endmodule

// File: tb/tb_pc_select.sv
// ----------------------------------------------------------------------------
// tb_pc_select
// Directed stimulus for pc_select. Each stimulus step pushes its hand-computed
// expected outputs into a queue; an independent monitor pops each entry and
// compares it against the DUT outputs at that moment.
// ----------------------------------------------------------------------------
module tb_pc_select;

    localparam int XLEN = 32;
`ifdef PC_SEL_ALIGN_EN
    localparam logic [31:0] TGT_F = 32'h0000_000C;
`else
    localparam logic [31:0] TGT_F = 32'h0000_000F;
`endif

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        trap;
        logic [31:0] mepc;
    } exp_t;

    logic I_clk;
    logic I_rst_n;

    pc_select_if #(.XLEN(XLEN)) bus ();

    pc_select #(.XLEN(XLEN)) dut (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .bus     (bus.slave)
    );

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Monitor: pops expectations and compares each output field.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            total++;
            if (bus.O_data === e.data) passed++;
            else $display("FAIL %s O_data: got %h expected %h", e.name, bus.O_data, e.data);
            total++;
            if (bus.O_trap === e.trap) passed++;
            else $display("FAIL %s O_trap: got %b expected %b", e.name, bus.O_trap, e.trap);
            total++;
            if (bus.O_mepc === e.mepc) passed++;
            else $display("FAIL %s O_mepc: got %h expected %h", e.name, bus.O_mepc, e.mepc);
        end
    end

    task automatic expect_out(input string name, input logic [31:0] d,
                              input logic t, input logic [31:0] m);
        exp_t e;
        e.name = name;
        e.data = d;
        e.trap = t;
        e.mepc = m;
        exp_q.push_back(e);
        #0;
    endtask

    // Drive one cycle's inputs just after the falling edge and check 1 time
    // unit later, well away from the rising edge.
    task automatic step(input string name, input logic intr, input logic [31:0] d,
                        input logic [31:0] ed, input logic et, input logic [31:0] em);
        @(negedge I_clk);
        bus.I_interrupt = intr;
        bus.I_data      = d;
        #1;
        expect_out(name, ed, et, em);
    endtask

    initial begin
        I_rst_n         = 1'b0;
        bus.I_interrupt = 1'b0;
        bus.I_mtvec     = 32'h0000_000F;
        bus.I_data      = 32'h0;
        #2;
        expect_out("reset", 32'h0, 1'b0, 32'h0);

        @(negedge I_clk);
        I_rst_n = 1'b1;

        // Normal forwarding.
        step("fwd1", 1'b0, 32'h1, 32'h1, 1'b0, 32'h0);
        step("fwd2", 1'b0, 32'h2, 32'h2, 1'b0, 32'h0);
        // First trap.
        step("trap1", 1'b1, 32'h3, TGT_F, 1'b1, 32'h0);
        // Held high: no retrigger, mepc captured.
        step("held", 1'b1, 32'h4, 32'h4, 1'b0, 32'h3);
        // Low for three cycles.
        step("low1", 1'b0, 32'h5, 32'h5, 1'b0, 32'h3);
        step("low2", 1'b0, 32'h6, 32'h6, 1'b0, 32'h3);
        step("low3", 1'b0, 32'h6, 32'h6, 1'b0, 32'h3);
        // Second trap.
        step("trap2", 1'b1, 32'h6, TGT_F, 1'b1, 32'h3);
        step("after2", 1'b1, 32'h7, 32'h7, 1'b0, 32'h6);
        step("drop", 1'b0, 32'h8, 32'h8, 1'b0, 32'h6);

        // Third trap with mtvec changing inside the trap cycle.
        @(negedge I_clk);
        bus.I_mtvec     = 32'h0000_0100;
        bus.I_interrupt = 1'b1;
        bus.I_data      = 32'h9;
        #1;
        expect_out("trap3_mtvec_a", 32'h0000_0100, 1'b1, 32'h6);
        bus.I_mtvec = 32'h0000_0200;
        #1;
        expect_out("trap3_mtvec_b", 32'h0000_0200, 1'b1, 32'h6);
        step("after3", 1'b1, 32'hA, 32'hA, 1'b0, 32'h9);

        // Asynchronous reset while interrupt is held high.
        #2;
        I_rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 32'h0000_0200, 1'b1, 32'h0);
        @(negedge I_clk);
        #1;
        expect_out("rst_hold", 32'h0000_0200, 1'b1, 32'h0);
        @(negedge I_clk);
        I_rst_n    = 1'b1;
        bus.I_data = 32'hB;
        #1;
        expect_out("rst_release_trap", 32'h0000_0200, 1'b1, 32'h0);
        step("post_rst", 1'b1, 32'hC, 32'hC, 1'b0, 32'hB);
        step("clear", 1'b0, 32'hD, 32'hD, 1'b0, 32'hB);

        // Short pulse that does not span a rising edge.
        @(negedge I_clk);
        bus.I_data = 32'hE;
        #1;
        expect_out("pulse_pre", 32'hE, 1'b0, 32'hB);
        bus.I_interrupt = 1'b1;
        #1;
        expect_out("pulse_hi", 32'h0000_0200, 1'b1, 32'hB);
        bus.I_interrupt = 1'b0;
        #1;
        expect_out("pulse_post", 32'hE, 1'b0, 32'hB);
        step("pulse_after", 1'b0, 32'hF, 32'hF, 1'b0, 32'hB);

        #5;
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_select.md
# pc_select

Next-PC source selector for the RISC-V core fetch stage. Each cycle it forwards the sequential/branch PC candidate from the PC-update logic, or redirects to the machine trap vector (`mtvec`) on the first cycle an interrupt request is seen. One clock edge-detect register ensures a level-held interrupt causes exactly one redirect. It also records the interrupted PC for the CSR unit (`mepc`).

## Interface
Parameters:
- `XLEN`, 32, datapath width of PC, `mtvec` and `mepc`.

Ports (one clock; reset is asynchronous and active-low):
- `I_clk`  in  1  core clock; all state updates on the rising edge.
- `I_rst_n`  in  1  asynchronous active-low reset.
- `I_interrupt`  in  1  interrupt request level from the interrupt controller.
- `I_mtvec`  in  XLEN  trap vector base from the CSR file.
- `I_data`  in  XLEN  normal next-PC candidate.
- `O_data`  out  XLEN  selected next PC.
- `O_trap`  out  1  high in the cycle a trap redirect is selected.
- `O_mepc`  out  XLEN  PC captured at the last trap redirect.

## Operation
- `int_q` is a flop holding the previous-cycle `I_interrupt`.
- Trap pulse: `O_trap = I_interrupt & ~int_q`. This is combinational, rising-edge detect only.
- `O_data = O_trap ? target : I_data`. This is combinational.
- `target` is `I_mtvec` by default. With `PC_SEL_ALIGN_EN` it is `{I_mtvec[XLEN-1:2], 2'b00}`.
- Holding `I_interrupt` high keeps `O_trap` low after the first cycle, and `O_data` returns to `I_data`.
- A new trap requires `I_interrupt` to drop for at least one sampled edge, then rise again.
- On each rising edge with `O_trap=1`, `O_mepc` is loaded with `I_data`. Otherwise it holds.
- No other state. Changes to `I_data` or `I_mtvec` propagate to `O_data` within the same cycle.

## Timing
- Reset (`I_rst_n=0`, asynchronous):
  - `int_q=0`, `O_mepc=0`.
  - `O_trap` and `O_data` still follow the combinational equations.
- Latency: zero cycles for `O_data`/`O_trap`. `O_mepc` is valid one edge after the trap cycle.
- `I_interrupt` rising between edges: `O_trap` asserts immediately and deasserts after the next rising edge samples `int_q=1`.
- Interrupt pulse shorter than one clock period that is not sampled high: the redirect appears only while the pulse is high. `int_q` stays 0.
- `I_interrupt` high at reset release: `int_q=0`, so a trap is taken in the first cycle after release.
- Reset asserted mid-trap cycle: `int_q` clears and `O_mepc` clears. A still-high `I_interrupt` re-triggers after release.
- `I_mtvec` changing during the trap cycle: the new value is forwarded combinationally.

## Configuration
- `PC_SEL_ALIGN_EN` defined: the trap target masks `mtvec[1:0]` to `00` (MODE bits ignored, word-aligned vector).
- Undefined: `I_mtvec` is passed through unmodified. The CSR unit is responsible for alignment.

## Test plan
- Reset, then `I_interrupt=0`, `I_mtvec=0x0000000F`, `I_data=0x1`, then `0x2` -> `O_data` follows `0x1`, `0x2`; `O_trap=0`; `O_mepc=0`.
- `I_interrupt` 0→1 with `I_data=0x3` -> that cycle `O_data=0xF` (or `0xC` with `PC_SEL_ALIGN_EN`) and `O_trap=1`; after the edge `O_mepc=0x3`.
- `I_interrupt` held high, `I_data=0x4` -> `O_data=0x4`, `O_trap=0`, `O_mepc` stays `0x3`.
- `I_interrupt` low for 3 cycles (`I_data` 5, 6), then high with `I_data=0x6` -> second redirect to the `mtvec` target; `O_mepc=0x6`.
- Assert `I_rst_n=0` while `I_interrupt=1` -> `int_q`/`O_mepc` clear asynchronously; after release the first cycle has `O_trap=1`.
- Interrupt pulse shorter than one clock period, not spanning an edge -> `O_data` redirected only during the pulse; `O_mepc` unchanged.
